nurse_call: RTL and testbench
=============================

// Module: nurse_call
// PURPOSE
//  Ward nurse-call controller: N bed call buttons are synchronised, latched as pending
//  requests, and the highest-priority pending request (bed 0 highest) is shown one-hot
//  on the LED bank with a binary bed code and a buzzer. A nurse acknowledge clears the
//  displayed request. Sits between the panel buttons and the nurse-station LED/buzzer drivers.
// PARAMETERS
//  N_BEDS       4   number of call inputs / LEDs (2..16)
//  SYNC_STAGES  2   flip-flop synchroniser depth per button and for ack (>=2)
//  BUZZ_DIV     4   buzzer toggles every BUZZ_DIV clk cycles while a request is pending (>=1)
// PORTS
//  clk    in   1                   system clock, all logic on rising edge
//  rst_n  in   1                   asynchronous active-low reset
//  call   in   N_BEDS              bed call buttons, active high, asynchronous to clk
//  ack    in   1                   nurse acknowledge, active high, asynchronous to clk
//  led    out  N_BEDS              one-hot highest-priority pending bed; all 0 when idle
//  code   out  $clog2(N_BEDS+1)    bed index+1 of the displayed request; 0 when idle
//  buzz   out  1                   square wave while any request is pending; 0 when idle
// BEHAVIOUR
//  - Reset (rst_n=0, async): synchronisers, pending, led, code, buzz, buzz counter all 0.
//  - call[i] and ack each pass through SYNC_STAGES FFs; a rising edge of the synchronised
//    signal (sync=1, previous=0) forms a one-cycle event. Held buttons raise one event only.
//  - pending[i] sets on call[i] rising-edge event; stays set until cleared by ack.
//  - Priority: lowest index wins. sel = lowest i with pending[i]=1.
//  - led, code, buzz are registered from pending: 1 clk after pending changes.
//    Latency call edge -> led: SYNC_STAGES+2 clk (sync, edge/pending, output reg).
//  - ack event clears pending[sel] only (the bed currently shown); ack with nothing pending
//    is ignored. Next-lower-priority pending bed is displayed on the following cycle.
//  - Simultaneous new call event and ack in the same cycle: ack clears the bed displayed
//    before this cycle's update; the new call is latched. If the new call is the same bed
//    as sel, the set wins (request stays pending).
//  - Multiple simultaneous call events: all latched; lowest index displayed first.
//  - buzz: counter runs only while any pending; toggles buzz every BUZZ_DIV cycles; on
//    becoming idle, counter and buzz return to 0 on the next clk.
//  - rst_n asserted mid-operation discards all pending requests immediately.
// STRUCTURE
//  - Shared package nurse_call_pkg: default N_BEDS, SYNC_STAGES, BUZZ_DIV constants and
//    function prio_onehot(vec) returning lowest-set-bit one-hot.
//  - One sub-module: nurse_call_sync (parameterised SYNC_STAGES synchroniser + rising-edge
//    detector, async active-low reset), instantiated per call bit and for ack.
//  - Top holds pending register, priority select, output registers, buzzer counter.
// TESTING (N_BEDS=4, SYNC_STAGES=2, BUZZ_DIV=4)
//  1 Reset: rst_n=0 with call=4'b1111 -> led=0, code=0, buzz=0 throughout reset.
//  2 Single call: pulse call=4'b0100 -> 4 clk later led=4'b0100, code=3, buzz toggling
//    every 4 clk; ack pulse -> led=0, code=0, buzz=0.
//  3 Priority: call=4'b1010 together -> led=4'b0010, code=2; ack -> led=4'b1000, code=4;
//    ack -> idle.
//  4 Held button: call[0] held high 20 clk, ack pulsed once mid-hold -> led=0 after ack,
//    no re-latch until call[0] released and pressed again.
//  5 Count sweep: call incremented 0..15 every 2 clk -> led always one-hot of lowest
//    pending bed, never multi-hot; final pending=4'b1111 drains in order 0,1,2,3 with 4 acks.
//  6 Async reset mid-operation: pending=4'b0110, rst_n pulsed low between clk edges ->
//    outputs 0 immediately, remain 0 after release with no new calls.

Source files
------------

// File: rtl/nurse_call_pkg.sv
// nurse_call_pkg
//   Shared constants and helpers for the ward nurse-call controller.
//   DEF_*       default parameter values used by nurse_call
//   MAX_BEDS    widest call bank supported; prio_onehot works on this width
//   prio_onehot returns a one-hot vector with the lowest set bit of vec
//               (all zeros when vec is zero)
package nurse_call_pkg;

    localparam int DEF_N_BEDS      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_BUZZ_DIV    = 4;
    localparam int MAX_BEDS        = 16;

    // Two's-complement trick: vec & -vec isolates the lowest set bit.
    function automatic logic [MAX_BEDS-1:0] prio_onehot(input logic [MAX_BEDS-1:0] vec);
        return vec & (~vec + MAX_BEDS'(1));
    endfunction

endpackage

// File: rtl/nurse_call_sync.sv
// nurse_call_sync
//   Multi-flop synchroniser for one asynchronous button line followed by a
//   rising-edge detector. A held input produces exactly one rise pulse.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   din    in  raw asynchronous input
//   rise   out one-cycle pulse when the synchronised input goes 0 -> 1
module nurse_call_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   prev_q;
    logic                   sync;

    assign sync = stages[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
            prev_q <= 1'b0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], din};
            prev_q <= sync;
        end
    end

    assign rise = sync & ~prev_q;

endmodule

// File: rtl/nurse_call.sv
// nurse_call
//   Ward nurse-call controller. Bed buttons are synchronised and latched as
//   pending requests; the lowest-index pending bed is shown one-hot on led
//   with its index+1 on code, and buzz runs as a square wave while anything
//   is pending. An ack pulse clears the bed currently selected.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   call   in  bed call buttons, active high, asynchronous
//   ack    in  nurse acknowledge, active high, asynchronous
//   led    out one-hot selected bed, zero when idle
//   code   out selected bed index+1, zero when idle
//   buzz   out toggles every BUZZ_DIV cycles while a request is pending
module nurse_call
    import nurse_call_pkg::*;
#(
    parameter int N_BEDS      = DEF_N_BEDS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int BUZZ_DIV    = DEF_BUZZ_DIV,
    localparam int CODE_W     = $clog2(N_BEDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BEDS-1:0] call,
    input  logic              ack,
    output logic [N_BEDS-1:0] led,
    output logic [CODE_W-1:0] code,
    output logic              buzz
);

    localparam int CNT_W = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BUZZ_DIV - 1);

    logic [N_BEDS-1:0] call_ev;
    logic              ack_ev;
    logic [N_BEDS-1:0] pending;
    logic [N_BEDS-1:0] pending_nxt;
    logic [N_BEDS-1:0] sel_oh;
    logic [N_BEDS-1:0] ack_clr;
    logic [CODE_W-1:0] code_nxt;
    logic [CNT_W-1:0]  buzz_cnt;

    for (genvar i = 0; i < N_BEDS; i++) begin : g_call_sync
        nurse_call_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (call[i]),
            .rise (call_ev[i])
        );
    end

    nurse_call_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ack),
        .rise (ack_ev)
    );

    assign sel_oh = N_BEDS'(prio_onehot(MAX_BEDS'(pending)));

    // Ack only clears the selected bed; a call event on that same bed in
    // the same cycle is OR-ed in afterwards so the new request survives.
    always_comb begin
        ack_clr     = ack_ev ? sel_oh : '0;
        pending_nxt = (pending & ~ack_clr) | call_ev;
    end

    always_comb begin
        code_nxt = '0;
        for (int i = 0; i < N_BEDS; i++) begin
            if (sel_oh[i]) begin
                code_nxt = CODE_W'(i + 1);
            end
        end
    end

    // Outputs follow the pending register one cycle later. The buzzer uses a
    // down-counter parked at zero when idle, so the first pending cycle
    // switches the buzzer on and each later toggle happens on terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            led      <= '0;
            code     <= '0;
            buzz     <= 1'b0;
            buzz_cnt <= '0;
        end else begin
            pending <= pending_nxt;
            led     <= sel_oh;
            code    <= code_nxt;
            if (pending == '0) begin
                buzz_cnt <= '0;
                buzz     <= 1'b0;
            end else if (buzz_cnt == '0) begin
                buzz_cnt <= CNT_RELOAD;
                buzz     <= ~buzz;
            end else begin
                buzz_cnt <= buzz_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nurse_call.sv
// tb_nurse_call
//   Randomised and directed stimulus for nurse_call with a scoreboard: a
//   behavioural model pushes the expected outputs for every clock, and a
//   monitor pops and compares them half a cycle later.
module tb_nurse_call;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int BD = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  call  = '0;
    logic          ack   = 1'b0;
    logic [N-1:0]  led;
    logic [CW-1:0] code;
    logic          buzz;

    nurse_call #(
        .N_BEDS     (N),
        .SYNC_STAGES(S),
        .BUZZ_DIV   (BD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .call (call),
        .ack  (ack),
        .led  (led),
        .code (code),
        .buzz (buzz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  led;
        logic [CW-1:0] code;
        logic          buzz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: input history, pending set as a plain bitmask, and
    // the number of cycles the current pending period has lasted.
    logic [N-1:0] call_hist[$];
    logic         ack_hist[$];
    int           m_pending = 0;
    int           m_age     = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lowest(input int v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        call_hist.delete();
        ack_hist.delete();
        for (int i = 0; i < S + 2; i++) begin
            call_hist.push_back('0);
            ack_hist.push_back(1'b0);
        end
        m_pending = 0;
        m_age     = 0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        exp_t         e;
        logic [N-1:0] cev;
        logic         aev;
        int           lo;
        if (!rst_n) begin
            model_reset();
            e = '0;
        end else begin
            // An input seen S edges ago is the synchronised value now; an
            // event is that value being 1 while the one before it was 0.
            call_hist.push_front(call);
            ack_hist.push_front(ack);
            cev = call_hist[S] & ~call_hist[S+1];
            aev = ack_hist[S] & ~ack_hist[S+1];
            void'(call_hist.pop_back());
            void'(ack_hist.pop_back());

            lo     = lowest(m_pending);
            e.led  = (lo < 0) ? '0 : N'(1 << lo);
            e.code = CW'(lo + 1);
            if (m_pending != 0) begin
                e.buzz = (((m_age / BD) % 2) == 0);
                m_age++;
            end else begin
                e.buzz = 1'b0;
                m_age  = 0;
            end

            if (aev && lo >= 0) m_pending = m_pending & ~(1 << lo);
            m_pending = m_pending | int'(cev);
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("led",    int'(led),  int'(e.led));
            chk("code",   int'(code), int'(e.code));
            chk("buzz",   int'(buzz), int'(e.buzz));
            chk("onehot", int'($countones(led) > 1), 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        cyc(2);
        ack = 1'b0;
        cyc(4);
    endtask

    task automatic drain();
        int guard = 0;
        call = '0;
        while (m_pending != 0 && guard < 40) begin
            pulse_ack();
            guard++;
        end
        chk("drain_done", m_pending, 0);
        cyc(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int want;

        // Reset with every button pressed: outputs held at zero.
        rst_n = 1'b0;
        call  = 4'b1111;
        cyc(4);
        chk("rst_led", int'(led), 0);
        chk("rst_code", int'(code), 0);
        chk("rst_buzz", int'(buzz), 0);
        call = '0;
        cyc(1);
        rst_n = 1'b1;
        cyc(3);

        // Single call on bed 2: visible four edges after the press.
        call = 4'b0100;
        cyc(2);
        call = '0;
        cyc(1);
        chk("single_early", int'(led), 0);
        cyc(1);
        chk("single_led", int'(led), 4);
        chk("single_code", int'(code), 3);
        chk("single_buzz_on", int'(buzz), 1);
        cyc(4);
        chk("single_buzz_tog", int'(buzz), 0);
        pulse_ack();
        chk("single_ack_led", int'(led), 0);
        chk("single_ack_code", int'(code), 0);
        chk("single_ack_buzz", int'(buzz), 0);

        // Two beds at once: lowest index shown first.
        call = 4'b1010;
        cyc(2);
        call = '0;
        cyc(4);
        chk("prio_led", int'(led), 2);
        chk("prio_code", int'(code), 2);
        pulse_ack();
        chk("prio_led2", int'(led), 8);
        chk("prio_code2", int'(code), 4);
        pulse_ack();
        chk("prio_idle", int'(led), 0);

        // Held button: one event only, no re-latch after ack while held.
        call = 4'b0001;
        cyc(8);
        pulse_ack();
        cyc(6);
        chk("held_cleared", int'(led), 0);
        call = '0;
        cyc(4);
        call = 4'b0001;
        cyc(6);
        chk("held_relatch", int'(led), 1);
        drain();

        // Count sweep, then drain in priority order.
        for (int i = 0; i < 16; i++) begin
            call = N'(i);
            cyc(2);
        end
        call = '0;
        cyc(6);
        chk("sweep_pending", m_pending, 15);
        chk("sweep_first", int'(led), 1);
        for (int k = 0; k < 4; k++) begin
            pulse_ack();
            want = (k < 3) ? (1 << (k + 1)) : 0;
            chk("sweep_drain", int'(led), want);
        end
        drain();

        // Randomised calls and acks.
        for (int i = 0; i < 300; i++) begin
            call = N'($urandom_range(0, 15));
            ack  = ($urandom_range(0, 3) == 0);
            cyc($urandom_range(1, 3));
        end
        ack = 1'b0;
        drain();

        // Asynchronous reset between clock edges with beds 1 and 2 pending.
        call = 4'b0110;
        cyc(2);
        call = '0;
        cyc(6);
        chk("areset_before", int'(led), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_led", int'(led), 0);
        chk("areset_code", int'(code), 0);
        chk("areset_buzz", int'(buzz), 0);
        #1 rst_n = 1'b1;
        cyc(10);
        chk("areset_after", int'(led), 0);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
